mor1kx_trace_capture: RTL
=========================

// Module: mor1kx_trace_capture
// PURPOSE
//  Synthesizable consumer of one mor1kx core's execute traceport. Buffers retired-instruction
//  records in a FIFO for a downstream drain (trace UART/debug reader) and tracks r3 as a shadow.
//  Detects the simulation-exit l.nop (0x15000001), raises finish and latches the r3 exit code.
//  One instance per core; in the dual-core SoC, instance N attaches to traceport index N.
// PARAMETERS
//  DEPTH      16            FIFO entries; power of two, >=2
//  AW         4             log2(DEPTH)
//  EXIT_INSN  32'h15000001  instruction word that terminates capture
//  COREID     0             core index, returned in rec_coreid_o
// PORTS
//  wb_clk_i                clk        in   1   system clock
//  wb_rst_i                rst        in   1   async reset, active-high
//  traceport_exec_valid_i  in   1   retired insn this cycle
//  traceport_exec_pc_i     in   32  PC of retired insn
//  traceport_exec_insn_i   in   32  instruction word
//  traceport_exec_wbdata_i in   32  GPR writeback data
//  traceport_exec_wbreg_i  in   5   GPR writeback index
//  traceport_exec_wben_i   in   1   GPR writeback enable
//  rec_valid_o             out  1   head record available
//  rec_ready_i             in   1   consumer accepts head record
//  rec_pc_o/insn_o/wbdata_o out 32  head record fields
//  rec_wbreg_o             out  5   head wbreg;  rec_wben_o  out 1  head wben
//  rec_coreid_o            out  8   COREID constant
//  count_o                 out  AW+1  entries held, 0..DEPTH
//  overflow_o              out  1   sticky: at least one record dropped
//  drop_cnt_o              out  16  dropped records, saturating
//  finish_o                out  1   exit insn retired (level, sticky)
//  exit_code_o             out  32  r3 value at exit
// BEHAVIOUR
//  Reset (async, any cycle): all outputs 0, FIFO empty, shadow r3=0, state RUN; mid-run reset
//   discards contents immediately, no partial record survives.
//  State: RUN -> FINISHED when valid_i && insn_i==EXIT_INSN; FINISHED held until reset.
//  Push: valid_i in RUN (incl. the exit insn itself) -> push {pc,insn,wbdata,wbreg,wben}.
//   In FINISHED, valid_i ignored: no push, no drop count, no r3 update.
//  Pop: rec_valid_o && rec_ready_i at a clock edge.
//  Latency: record pushed at edge N is visible at rec_* after edge N (rec_valid_o=1 in cycle N+1
//   when FIFO was empty). rec_* stable while rec_valid_o && !rec_ready_i.
//  Full: push with count==DEPTH and no pop -> record dropped, overflow_o<=1,
//   drop_cnt_o+=1 saturating at 16'hFFFF. Push+pop same edge when full -> both happen, no drop.
//  Empty: rec_ready_i with rec_valid_o=0 is ignored; count never underflows.
//  Simultaneous push+pop any other count: count unchanged, order preserved.
//  Pointers AW+1 bits, wrap modulo 2*DEPTH; full = MSBs differ, lower AW bits equal.
//  Shadow r3: valid_i && wben_i && wbreg_i==3 in RUN -> shadow<=wbdata_i.
//  Exit: exit_code_o<=shadow r3 (old value; the exit insn's own r3 writeback, if any, not used);
//   finish_o<=1 same edge. Records pushed before exit stay drainable after finish.
//  rec_* when rec_valid_o=0: hold last value (don't care for checking).
// TESTING
//  reset release, 3 valid insns pc 0x100/0x104/0x108, ready=1 -> rec_pc 0x100,0x104,0x108 in order,
//   each one cycle after push; count returns 0.
//  ready=0, 18 pushes with DEPTH=16 -> count_o=16, overflow_o=1, drop_cnt_o=2; drain gives first 16 pcs.
//  full FIFO, push+pop same cycle -> count stays 16, drop_cnt unchanged, new pc at tail.
//  write r3=0x2A (wbreg 3, wben 1), then insn 0x15000001 -> finish_o=1, exit_code_o=0x2A;
//   later valid_i is not captured.
//  assert wb_rst_i mid-burst with count=5 -> same cycle rec_valid_o=0, count_o=0, finish_o=0;
//   capture resumes after release.

Source files
------------

// File: rtl/mor1kx_trace_capture.sv
// rtl/mor1kx_trace_capture.sv - retired-instruction trace FIFO with r3 shadow and sim-exit detect
// One instance per core traceport; records drain through a valid/ready head interface.
module mor1kx_trace_capture #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter logic [31:0] EXIT_INSN = 32'h15000001,
  parameter logic [7:0]  COREID    = 8'd0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          traceport_exec_valid_i,
  input  logic [31:0]   traceport_exec_pc_i,
  input  logic [31:0]   traceport_exec_insn_i,
  input  logic [31:0]   traceport_exec_wbdata_i,
  input  logic [4:0]    traceport_exec_wbreg_i,
  input  logic          traceport_exec_wben_i,
  output logic          rec_valid_o,
  input  logic          rec_ready_i,
  output logic [31:0]   rec_pc_o,
  output logic [31:0]   rec_insn_o,
  output logic [31:0]   rec_wbdata_o,
  output logic [4:0]    rec_wbreg_o,
  output logic          rec_wben_o,
  output logic [7:0]    rec_coreid_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o,
  output logic [15:0]   drop_cnt_o,
  output logic          finish_o,
  output logic [31:0]   exit_code_o
);

  localparam int          RW      = 102;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {ST_RUN = 1'b0, ST_FINISHED = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           in_run;
  logic           exit_hit;
  logic [RW-1:0]  mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [31:0]    shadow_r3;
  logic           empty, full, push_req, push, pop, drop;

  always_comb begin
    state_d  = state_q;
    in_run   = 1'b0;
    exit_hit = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_run = 1'b1;
        if (traceport_exec_valid_i && traceport_exec_insn_i == EXIT_INSN) begin
          exit_hit = 1'b1;
          state_d  = ST_FINISHED;
        end
      end
      default: state_d = ST_FINISHED;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && rec_ready_i;
  assign push_req = traceport_exec_valid_i && in_run;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_o  <= 1'b0;
      drop_cnt_o  <= 16'd0;
      shadow_r3   <= 32'd0;
      exit_code_o <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {traceport_exec_pc_i, traceport_exec_insn_i,
                                traceport_exec_wbdata_i, traceport_exec_wbreg_i,
                                traceport_exec_wben_i};
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end
      // Exit code takes the pre-exit r3; the exit insn's own writeback is ignored.
      if (exit_hit) exit_code_o <= shadow_r3;
      if (push_req && traceport_exec_wben_i && traceport_exec_wbreg_i == 5'd3)
        shadow_r3 <= traceport_exec_wbdata_i;
    end
  end

  assign rec_valid_o  = !empty;
  assign rec_pc_o     = mem[rd_ptr[AW-1:0]][101:70];
  assign rec_insn_o   = mem[rd_ptr[AW-1:0]][69:38];
  assign rec_wbdata_o = mem[rd_ptr[AW-1:0]][37:6];
  assign rec_wbreg_o  = mem[rd_ptr[AW-1:0]][5:1];
  assign rec_wben_o   = mem[rd_ptr[AW-1:0]][0];
  assign rec_coreid_o = COREID;
  assign count_o      = wr_ptr - rd_ptr;
  assign finish_o     = (state_q == ST_FINISHED);

endmodule
